// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Multi-cycle core controller. It runs one instruction at a time through
//   FETCH -> DECODE -> EXEC -> (MEM) -> WB. Each stage gets a one-cycle enable
//   pulse when the sequencer enters it, and the sequencer then waits for that
//   stage's done flag. Illegal instructions and stage watchdog expiry raise a
//   trap. The trap is held until trap_ack, after which fetch restarts.
//
// Parameters
//   TIMEOUT : number of wait cycles allowed after a stage pulse (0 = no watchdog)
//   CNT_W   : width of the cycle and retired-instruction counters
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   run                 : level; 0 stops the core at the next instruction boundary
//   <stage>_en / _done  : enable pulse out, completion flag in (fetch/decode/exec/mem/wb)
//   is_load/is_store/is_illegal : decode results, sampled when decode_done is seen
//   trap_valid/trap_cause/trap_ack : trap report (1 = illegal, 2 = timeout)
//   busy, state         : debug view of the FSM
//   cycle_count         : cycles spent outside IDLE
//   instret_count       : retired instructions
module stage_sequencer #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic             fetch_en,
   input  logic             fetch_done,
   output logic             decode_en,
   input  logic             decode_done,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             is_illegal,
   output logic             exec_en,
   input  logic             exec_done,
   output logic             mem_en,
   input  logic             mem_done,
   output logic             wb_en,
   input  logic             wb_done,
   output logic             trap_valid,
   output logic [1:0]       trap_cause,
   input  logic             trap_ack,
   output logic             busy,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instret_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   // The watchdog counter only has to reach TIMEOUT-1. Entering TRAP takes
   // the place of the final increment.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t        st;
   logic [TW-1:0] tmo;
   logic          is_mem;    // load/store flag captured at decode_done
   logic          pulse;     // first cycle in a stage; done is ignored here
   logic          done_sel;  // done flag of the currently active stage
   logic          tmo_hit;

   assign state = st;
   assign busy  = (st != S_IDLE);

   // Only the active stage has its enable high, so the OR of all enables
   // marks the pulse cycle.
   assign pulse   = fetch_en | decode_en | exec_en | mem_en | wb_en;
   assign tmo_hit = (TIMEOUT > 0) && (tmo == TW'(TIMEOUT - 1));

   always_comb begin
      done_sel = 1'b0;
      case (st)
         S_FETCH:  done_sel = fetch_done;
         S_DECODE: done_sel = decode_done;
         S_EXEC:   done_sel = exec_done;
         S_MEM:    done_sel = mem_done;
         S_WB:     done_sel = wb_done;
         default:  done_sel = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st            <= S_IDLE;
         fetch_en      <= 1'b0;
         decode_en     <= 1'b0;
         exec_en       <= 1'b0;
         mem_en        <= 1'b0;
         wb_en         <= 1'b0;
         trap_valid    <= 1'b0;
         trap_cause    <= 2'd0;
         tmo           <= '0;
         is_mem        <= 1'b0;
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         // Enables are single-cycle. Only the branch that enters a stage sets one.
         fetch_en  <= 1'b0;
         decode_en <= 1'b0;
         exec_en   <= 1'b0;
         mem_en    <= 1'b0;
         wb_en     <= 1'b0;

         if (st != S_IDLE)
            cycle_count <= cycle_count + 1'b1;

         case (st)
            S_IDLE: begin
               if (run) begin
                  st       <= S_FETCH;
                  fetch_en <= 1'b1;
                  tmo      <= '0;
               end
            end

            S_TRAP: begin
               if (trap_ack) begin
                  trap_valid <= 1'b0;
                  trap_cause <= 2'd0;
                  st         <= S_FETCH;
                  fetch_en   <= 1'b1;
                  tmo        <= '0;
               end
            end

            default: begin
               if (!pulse) begin
                  // When done and timeout land in the same cycle, done wins.
                  if (done_sel) begin
                     tmo <= '0;
                     case (st)
                        S_FETCH: begin
                           st        <= S_DECODE;
                           decode_en <= 1'b1;
                        end
                        S_DECODE: begin
                           is_mem <= is_load | is_store;
                           if (is_illegal) begin
                              st         <= S_TRAP;
                              trap_valid <= 1'b1;
                              trap_cause <= 2'd1;
                           end else begin
                              st      <= S_EXEC;
                              exec_en <= 1'b1;
                           end
                        end
                        S_EXEC: begin
                           if (is_mem) begin
                              st     <= S_MEM;
                              mem_en <= 1'b1;
                           end else begin
                              st    <= S_WB;
                              wb_en <= 1'b1;
                           end
                        end
                        S_MEM: begin
                           st    <= S_WB;
                           wb_en <= 1'b1;
                        end
                        S_WB: begin
                           instret_count <= instret_count + 1'b1;
                           if (run) begin
                              st       <= S_FETCH;
                              fetch_en <= 1'b1;
                           end else begin
                              st <= S_IDLE;
                           end
                        end
                        default: st <= S_IDLE;
                     endcase
                  end else if (tmo_hit) begin
                     st         <= S_TRAP;
                     trap_valid <= 1'b1;
                     trap_cause <= 2'd2;
                     tmo        <= '0;
                  end else if (TIMEOUT > 0) begin
                     tmo <= tmo + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule
